// File: rtl/rv_p4_pkg.sv
// rtl/rv_p4_pkg.sv - shared types for the MAU configuration write scheduler
package rv_p4_pkg;

  typedef enum logic [1:0] {
    KIND_ENTRY      = 2'd0,
    KIND_TCAM_ONLY  = 2'd1,
    KIND_ASRAM_ONLY = 2'd2,
    KIND_INVALIDATE = 2'd3
  } cfg_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ASRAM,
    ST_WR_TCAM,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    cfg_kind_e      kind;
    logic [10:0]    tcam_addr;
    logic [511:0]   key;
    logic [511:0]   mask;
    logic [15:0]    action_id;
    logic [15:0]    action_ptr;
    logic [15:0]    asram_addr;
    logic [127:0]   asram_data;
  } cfg_req_t;

  // Field order matches the concatenation of the TCAM write port outputs.
  typedef struct packed {
    logic           valid;
    logic [10:0]    addr;
    logic [511:0]   key;
    logic [511:0]   mask;
    logic [15:0]    action_id;
    logic [15:0]    action_ptr;
  } tcam_wr_t;

  function automatic tcam_wr_t tcam_word(cfg_req_t r);
    tcam_wr_t t;
    t = '0;
    t.addr = r.tcam_addr;
    if (r.kind != KIND_INVALIDATE) begin
      t.valid      = 1'b1;
      t.key        = r.key;
      t.mask       = r.mask;
      t.action_id  = r.action_id;
      t.action_ptr = r.action_ptr;
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter with one-hot grant and explicit pointer advance
module rr_arb #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_dp,
  input  logic          rst_dp_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts at ptr and wraps; the first requesting index wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  always_ff @(posedge clk_dp) begin
    if (!rst_dp_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mau_cfg_sched.sv
// rtl/mau_cfg_sched.sv - arbitrates config requesters and sequences ASRAM/TCAM writes for one MAU stage
module mau_cfg_sched
  import rv_p4_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int STAGE_ID = 0
) (
  input  logic               clk_dp,
  input  logic               rst_dp_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  cfg_req_t           req [N_REQ],
  input  logic               cfg_hold,
  output logic               tcam_wr_en,
  output logic [10:0]        tcam_wr_addr,
  output logic [511:0]       tcam_wr_key,
  output logic [511:0]       tcam_wr_mask,
  output logic [15:0]        tcam_action_id,
  output logic [15:0]        tcam_action_ptr,
  output logic               tcam_wr_valid,
  output logic               asram_wr_en,
  output logic [15:0]        asram_wr_addr,
  output logic [127:0]       asram_wr_data,
  output logic [N_REQ-1:0]   done,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e   state;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]  gnt_idx;
  logic [IW-1:0]  owner;
  logic           hs;
  cfg_req_t       sel;
  tcam_wr_t       sel_tcam;
  tcam_wr_t       lat_tcam;
  cfg_kind_e      lat_kind;
  logic           unused_asram_hi;

  rr_arb #(.N(N_REQ)) u_arb (
    .clk_dp   (clk_dp),
    .rst_dp_n (rst_dp_n),
    .req      (req_valid),
    .advance  (hs),
    .grant    (grant),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = (rst_dp_n && state == ST_IDLE && !cfg_hold) ? grant : '0;
  assign hs        = |(req_ready & req_valid);
  assign sel       = req[gnt_idx];
  assign sel_tcam  = tcam_word(sel);
  // The top 16 bits of the ASRAM word are replaced by the action id.
  assign unused_asram_hi = ^sel.asram_data[127:112];

  always_ff @(posedge clk_dp) begin
    if (!rst_dp_n) begin
      state           <= ST_IDLE;
      owner           <= '0;
      lat_kind        <= KIND_ENTRY;
      lat_tcam        <= '0;
      busy            <= 1'b0;
      done            <= '0;
      asram_wr_en     <= 1'b0;
      asram_wr_addr   <= '0;
      asram_wr_data   <= '0;
      tcam_wr_en      <= 1'b0;
      {tcam_wr_valid, tcam_wr_addr, tcam_wr_key, tcam_wr_mask,
       tcam_action_id, tcam_action_ptr} <= '0;
    end else begin
      tcam_wr_en  <= 1'b0;
      asram_wr_en <= 1'b0;
      done        <= '0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            owner    <= gnt_idx;
            lat_kind <= sel.kind;
            lat_tcam <= sel_tcam;
            busy     <= 1'b1;
            if (sel.kind == KIND_ENTRY || sel.kind == KIND_ASRAM_ONLY) begin
              state         <= ST_WR_ASRAM;
              asram_wr_en   <= 1'b1;
              asram_wr_addr <= sel.asram_addr;
              asram_wr_data <= {sel.action_id, sel.asram_data[111:0]};
            end else begin
              state      <= ST_WR_TCAM;
              tcam_wr_en <= 1'b1;
              {tcam_wr_valid, tcam_wr_addr, tcam_wr_key, tcam_wr_mask,
               tcam_action_id, tcam_action_ptr} <= sel_tcam;
            end
          end
        end
        ST_WR_ASRAM: begin
          // ASRAM goes first so a TCAM hit never points at stale action data.
          if (lat_kind == KIND_ENTRY) begin
            state      <= ST_WR_TCAM;
            tcam_wr_en <= 1'b1;
            {tcam_wr_valid, tcam_wr_addr, tcam_wr_key, tcam_wr_mask,
             tcam_action_id, tcam_action_ptr} <= lat_tcam;
          end else begin
            state       <= ST_DONE;
            done[owner] <= 1'b1;
          end
        end
        ST_WR_TCAM: begin
          state       <= ST_DONE;
          done[owner] <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_dp) begin
    if (rst_dp_n) begin
      assert ($onehot0(req_ready))
        else $error("mau_cfg_sched stage %0d: more than one req_ready high", STAGE_ID);
    end
  end

endmodule

// File: tb/tb_mau_cfg_sched.sv
// tb/tb_mau_cfg_sched.sv - directed bench with a schedule-queue reference model for mau_cfg_sched
module tb_mau_cfg_sched;
  import rv_p4_pkg::*;

  localparam int N = 4;

  logic           clk_dp = 1'b0;
  logic           rst_dp_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  cfg_req_t       req_a [N];
  logic           cfg_hold = 1'b0;
  logic           tcam_wr_en;
  logic [10:0]    tcam_wr_addr;
  logic [511:0]   tcam_wr_key;
  logic [511:0]   tcam_wr_mask;
  logic [15:0]    tcam_action_id;
  logic [15:0]    tcam_action_ptr;
  logic           tcam_wr_valid;
  logic           asram_wr_en;
  logic [15:0]    asram_wr_addr;
  logic [127:0]   asram_wr_data;
  logic [N-1:0]   done;
  logic           busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_dp = ~clk_dp;

  mau_cfg_sched #(.N_REQ(N), .STAGE_ID(3)) dut (
    .clk_dp          (clk_dp),
    .rst_dp_n        (rst_dp_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req             (req_a),
    .cfg_hold        (cfg_hold),
    .tcam_wr_en      (tcam_wr_en),
    .tcam_wr_addr    (tcam_wr_addr),
    .tcam_wr_key     (tcam_wr_key),
    .tcam_wr_mask    (tcam_wr_mask),
    .tcam_action_id  (tcam_action_id),
    .tcam_action_ptr (tcam_action_ptr),
    .tcam_wr_valid   (tcam_wr_valid),
    .asram_wr_en     (asram_wr_en),
    .asram_wr_addr   (asram_wr_addr),
    .asram_wr_data   (asram_wr_data),
    .done            (done),
    .busy            (busy)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // One record per cycle of an in-flight sequence: what the outputs must show.
  typedef struct {
    logic           a_en;
    logic [15:0]    a_addr;
    logic [127:0]   a_data;
    logic           t_en;
    logic           t_valid;
    logic [10:0]    t_addr;
    logic [511:0]   t_key;
    logic [511:0]   t_mask;
    logic [15:0]    t_aid;
    logic [15:0]    t_aptr;
    logic [N-1:0]   done;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;
  logic prev_rst_n = 1'b1;
  bit   armed = 1'b0;

  task automatic plan(input cfg_req_t r, input int g);
    exp_t w, t, d;
    w = '{default: 0};
    t = '{default: 0};
    d = '{default: 0};
    w.a_en   = 1'b1;
    w.a_addr = r.asram_addr;
    w.a_data = {r.action_id, r.asram_data[111:0]};
    t.t_en   = 1'b1;
    t.t_addr = r.tcam_addr;
    if (r.kind != KIND_INVALIDATE) begin
      t.t_valid = 1'b1;
      t.t_key   = r.key;
      t.t_mask  = r.mask;
      t.t_aid   = r.action_id;
      t.t_aptr  = r.action_ptr;
    end
    d.done[g] = 1'b1;
    if (r.kind == KIND_ENTRY) begin
      q.push_back(w);
      q.push_back(t);
    end else if (r.kind == KIND_ASRAM_ONLY) begin
      q.push_back(w);
    end else begin
      q.push_back(t);
    end
    q.push_back(d);
  endtask

  always @(negedge clk_dp) begin
    exp_t         e;
    logic [N-1:0] e_ready;
    logic         e_busy;
    int           g;
    e       = '{default: 0};
    e_ready = '0;
    e_busy  = 1'b0;
    g       = -1;
    if (q.size() > 0) begin
      e      = q.pop_front();
      e_busy = 1'b1;
    end else if (rst_dp_n && !cfg_hold) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        e_ready[g] = 1'b1;
        m_ptr = (g + 1) % N;
        plan(req_a[g], g);
      end
    end
    if (armed) begin
      chk("m_ready", 512'(req_ready), 512'(e_ready));
      chk("m_busy", 512'(busy), 512'(e_busy));
      chk("m_done", 512'(done), 512'(e.done));
      chk("m_asram_en", 512'(asram_wr_en), 512'(e.a_en));
      chk("m_tcam_en", 512'(tcam_wr_en), 512'(e.t_en));
      if (e.a_en || !prev_rst_n) begin
        chk("m_asram_addr", 512'(asram_wr_addr), 512'(e.a_addr));
        chk("m_asram_data", 512'(asram_wr_data), 512'(e.a_data));
      end
      if (e.t_en || !prev_rst_n) begin
        chk("m_tcam_valid", 512'(tcam_wr_valid), 512'(e.t_valid));
        chk("m_tcam_addr", 512'(tcam_wr_addr), 512'(e.t_addr));
        chk("m_tcam_key", tcam_wr_key, e.t_key);
        chk("m_tcam_mask", tcam_wr_mask, e.t_mask);
        chk("m_tcam_aid", 512'(tcam_action_id), 512'(e.t_aid));
        chk("m_tcam_aptr", 512'(tcam_action_ptr), 512'(e.t_aptr));
      end
    end
    if (!rst_dp_n) begin
      q.delete();
      m_ptr = 0;
      armed = 1'b1;
    end
    prev_rst_n = rst_dp_n;
  end

  function automatic cfg_req_t mk(cfg_kind_e k, logic [10:0] ta, logic [15:0] aa,
                                  logic [15:0] aid, logic [31:0] seed);
    cfg_req_t r;
    r.kind       = k;
    r.tcam_addr  = ta;
    r.key        = {16{seed}};
    r.mask       = {16{~seed}};
    r.action_id  = aid;
    r.action_ptr = aid ^ 16'h5A5A;
    r.asram_addr = aa;
    r.asram_data = {4{seed}};
    return r;
  endfunction

  task automatic step();
    @(posedge clk_dp);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_dp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int grants[$];
    int dcnt[N];
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) req_a[i] = '0;

    // Reset values
    repeat (3) step();
    at_neg();
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_tcam_en", 512'(tcam_wr_en), 512'(0));
    chk("rst_asram_en", 512'(asram_wr_en), 512'(0));
    chk("rst_asram_data", 512'(asram_wr_data), 512'(0));
    step();
    rst_dp_n = 1'b1;
    repeat (2) step();

    // Single ENTRY from requester 2
    req_a[2]  = mk(KIND_ENTRY, 11'd5, 16'd1, 16'hA000, 32'h1234_5678);
    req_valid = 4'b0100;
    at_neg();
    chk("entry_ready_T", 512'(req_ready), 512'(4'b0100));
    step();
    req_valid = '0;
    at_neg();
    chk("entry_asram_en_T1", 512'(asram_wr_en), 512'(1));
    chk("entry_asram_hi", 512'(asram_wr_data[127:112]), 512'(16'hA000));
    chk("entry_asram_lo", 512'(asram_wr_data[15:0]), 512'(16'h5678));
    chk("entry_asram_addr", 512'(asram_wr_addr), 512'(1));
    chk("entry_tcam_en_T1", 512'(tcam_wr_en), 512'(0));
    step();
    at_neg();
    chk("entry_tcam_en_T2", 512'(tcam_wr_en), 512'(1));
    chk("entry_tcam_addr", 512'(tcam_wr_addr), 512'(5));
    chk("entry_tcam_valid", 512'(tcam_wr_valid), 512'(1));
    chk("entry_asram_en_T2", 512'(asram_wr_en), 512'(0));
    step();
    at_neg();
    chk("entry_done_T3", 512'(done), 512'(4'b0100));
    chk("entry_tcam_en_T3", 512'(tcam_wr_en), 512'(0));
    step();
    at_neg();
    chk("entry_idle_T4", 512'(busy), 512'(0));
    chk("entry_done_T4", 512'(done), 512'(0));
    step();

    // INVALIDATE addr 7 from requester 0 (nonzero key/action in the request)
    req_a[0]  = mk(KIND_INVALIDATE, 11'd7, 16'd3, 16'h7777, 32'hCAFE_F00D);
    req_valid = 4'b0001;
    at_neg();
    chk("inv_ready_T", 512'(req_ready), 512'(4'b0001));
    step();
    req_valid = '0;
    at_neg();
    chk("inv_tcam_en", 512'(tcam_wr_en), 512'(1));
    chk("inv_tcam_addr", 512'(tcam_wr_addr), 512'(7));
    chk("inv_tcam_valid", 512'(tcam_wr_valid), 512'(0));
    chk("inv_tcam_key", tcam_wr_key, 512'(0));
    chk("inv_tcam_mask", tcam_wr_mask, 512'(0));
    chk("inv_tcam_aid", 512'(tcam_action_id), 512'(0));
    chk("inv_asram_en", 512'(asram_wr_en), 512'(0));
    step();
    at_neg();
    chk("inv_done", 512'(done), 512'(4'b0001));
    chk("inv_asram_en2", 512'(asram_wr_en), 512'(0));
    repeat (2) step();

    // Reset at T+1 of an ENTRY from requester 1
    req_a[1]  = mk(KIND_ENTRY, 11'd12, 16'd4, 16'h1111, 32'h0BAD_BEEF);
    req_valid = 4'b0010;
    at_neg();
    chk("rstmid_ready_T", 512'(req_ready), 512'(4'b0010));
    step();
    req_valid = '0;
    rst_dp_n  = 1'b0;
    at_neg();
    chk("rstmid_asram_T1", 512'(asram_wr_en), 512'(1));
    step();
    at_neg();
    chk("rstmid_tcam_en", 512'(tcam_wr_en), 512'(0));
    chk("rstmid_busy", 512'(busy), 512'(0));
    step();
    rst_dp_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("rstmid_no_tcam", 512'(tcam_wr_en), 512'(0));
      chk("rstmid_no_done", 512'(done), 512'(0));
      step();
    end

    // All four requesters continuously valid with TCAM_ONLY
    for (int i = 0; i < N; i++)
      req_a[i] = mk(KIND_TCAM_ONLY, 11'(16 + i), 16'(i), 16'(16'h0100 + i), 32'(32'h1000_0001 * (i + 1)));
    for (int i = 0; i < N; i++) dcnt[i] = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      at_neg();
      chk("rr_onehot", 512'($onehot0(req_ready)), 512'(1));
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) grants.push_back(i);
        if (c < 12 && done[i]) dcnt[i]++;
      end
    end
    step();
    req_valid = '0;
    chk("rr_grant_count", 512'(grants.size()), 512'(5));
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) chk("rr_order", 512'(grants[i]), 512'(ord[i]));
    for (int i = 0; i < N; i++) chk("rr_done_once", 512'(dcnt[i]), 512'(1));
    repeat (4) step();

    // cfg_hold blocks grants; release grants within one cycle
    req_a[1]  = mk(KIND_ASRAM_ONLY, 11'd0, 16'h0042, 16'h2222, 32'h5555_AAAA);
    cfg_hold  = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      chk("hold_ready", 512'(req_ready), 512'(0));
    end
    step();
    cfg_hold = 1'b0;
    at_neg();
    chk("hold_release", 512'(req_ready), 512'(4'b0010));
    step();
    req_valid = '0;
    repeat (4) step();

    // cfg_hold raised at T+1 of an ENTRY from requester 3; a request dropped during hold
    req_a[3]  = mk(KIND_ENTRY, 11'd9, 16'h0009, 16'hBEEF, 32'h3333_4444);
    req_valid = 4'b1000;
    at_neg();
    chk("hmid_ready_T", 512'(req_ready), 512'(4'b1000));
    step();
    cfg_hold  = 1'b1;
    req_a[0]  = mk(KIND_ENTRY, 11'd30, 16'h0030, 16'h3030, 32'h6666_7777);
    req_valid = 4'b0001;
    at_neg();
    chk("hmid_asram_T1", 512'(asram_wr_en), 512'(1));
    step();
    at_neg();
    chk("hmid_tcam_T2", 512'(tcam_wr_en), 512'(1));
    chk("hmid_tcam_addr", 512'(tcam_wr_addr), 512'(9));
    step();
    at_neg();
    chk("hmid_done_T3", 512'(done), 512'(4'b1000));
    step();
    at_neg();
    chk("hmid_blocked", 512'(req_ready), 512'(0));
    step();
    req_valid = '0;
    step();
    cfg_hold = 1'b0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("drop_no_asram", 512'(asram_wr_en), 512'(0));
      chk("drop_no_tcam", 512'(tcam_wr_en), 512'(0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mau_cfg_sched.md
MAU_CFG_SCHED -- requirements
Module: mau_cfg_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of config requesters (host, CPU, learn, aging).
REQ-002 SHALL have parameter STAGE_ID, default 0: MAU stage served; used only in assertions and messages.
REQ-003 SHALL have port clk_dp, input, 1: datapath clock; the only clock.
REQ-004 SHALL have port rst_dp_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, N_REQ: per-requester request valid.
REQ-006 SHALL have port req_ready, output, N_REQ: per-requester accept; at most one bit high.
REQ-007 SHALL have port req, input, N_REQ x cfg_req_t: per-requester request payload.
REQ-008 SHALL have port cfg_hold, input, 1: quiesce request; blocks new grants.
REQ-009 SHALL have ports tcam_wr_en (1), tcam_wr_addr (11), tcam_wr_key (512), tcam_wr_mask (512), tcam_action_id (16), tcam_action_ptr (16), tcam_wr_valid (1), all outputs: TCAM write port of mau_cfg_if.
REQ-010 SHALL have ports asram_wr_en (1), asram_wr_addr (16), asram_wr_data (128), all outputs: Action SRAM write port of mau_cfg_if.
REQ-011 SHALL have port done, output, N_REQ: one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL use cfg_req_t fields: kind (2b: ENTRY=0, TCAM_ONLY=1, ASRAM_ONLY=2, INVALIDATE=3), tcam_addr, key, mask, action_id, action_ptr, asram_addr, asram_data.
REQ-014 SHALL implement FSM states IDLE, WR_ASRAM, WR_TCAM, DONE.
REQ-015 SHALL, in IDLE with cfg_hold=0, grant round-robin among valid requesters, starting at the index after the last granted one; after reset the search starts at index 0.
REQ-016 SHALL drive req_ready combinationally high only for the granted index, only in IDLE, and only when cfg_hold=0.
REQ-017 SHALL latch the payload and requester index on the handshake (valid&ready) cycle T.
REQ-018 SHALL advance the round-robin pointer only on a handshake.
REQ-019 SHALL, for ENTRY: write ASRAM at T+1, write TCAM at T+2, enter DONE at T+3. ASRAM is written before TCAM so no hit reads stale action data.
REQ-020 SHALL, for ASRAM_ONLY: WR_ASRAM at T+1, DONE at T+2.
REQ-021 SHALL, for TCAM_ONLY: WR_TCAM at T+1, DONE at T+2.
REQ-022 SHALL, for INVALIDATE: WR_TCAM at T+1 with tcam_wr_valid=0, key=0, mask=0, action fields=0; DONE at T+2.
REQ-023 SHALL assert each write enable for exactly one cycle per write; data outputs are valid during that cycle.
REQ-024 SHALL drive tcam_wr_valid=1 for ENTRY and TCAM_ONLY.
REQ-025 SHALL form asram_wr_data as {action_id, low 112 bits of asram_data}.
REQ-026 SHALL pulse done[idx] for one cycle in DONE, then return to IDLE; a new grant is possible the cycle after DONE.
REQ-027 SHALL let cfg_hold asserted mid-operation delay nothing: the current sequence completes and only the next grant is blocked.
REQ-028 SHALL keep a request with valid deasserted before its handshake unserved, with no side effects.
REQ-029 SHALL NOT register or use request payload on non-handshake cycles.

Reset
REQ-030 SHALL, on rst_dp_n=0 at a clock edge: FSM to IDLE, RR pointer to 0, all outputs 0 (enables, data, req_ready, done, busy).
REQ-031 SHALL abort any operation when reset is asserted mid-operation: no further write enables, and no done pulse for the aborted request.

Structure
REQ-032 SHALL place cfg_req_t, the kind encoding and the FSM state enum in rv_p4_pkg.
REQ-033 SHALL implement the round-robin grant in sub-module rr_arb (parameterised N, one-hot grant, pointer update input).

Verification
REQ-034 Single ENTRY from requester 2 (tcam_addr=5, asram_addr=1, action_id=0xA000): ASRAM write at T+1 with data[127:112]=0xA000, TCAM write at T+2 addr 5 valid=1, done[2] at T+3.
REQ-035 All 4 requesters valid continuously with TCAM_ONLY: grant order 0,1,2,3,0; each done once per 3 cycles; never two ready bits high.
REQ-036 INVALIDATE addr 7: single TCAM write, addr 7, valid=0, key=mask=0, no ASRAM write.
REQ-037 cfg_hold=1 with req_valid[1]=1: req_ready stays 0 for 10 cycles; hold released: grant within 1 cycle.
REQ-038 Reset asserted at cycle T+1 of an ENTRY: no TCAM write, no done, outputs 0, next grant starts at index 0.
REQ-039 cfg_hold asserted at T+1 of an ENTRY: TCAM write and done still occur on schedule.
